chunked_seq_adder: RTL and testbench
====================================

Name: chunked_seq_adder

Overview:
Parametrised multi-cycle adder/subtractor for W-bit operands. It processes CHUNK bits per clock through a registered carry, trading latency for a short combinational carry chain. Operands and results move over valid/ready handshakes, so the block sits between the operand register file and the result/display path in the lab datapath. It generalises the 16-bit ripple adder: width and chunking are parameters, subtract mode is added, and signed overflow is reported.

Parameters:
W, 16, operand/result width; must be a multiple of CHUNK.
CHUNK, 4, bits summed per BUSY cycle; 1 <= CHUNK <= W.
N (localparam), W/CHUNK, number of BUSY cycles per operation.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand set presented.
in_ready  output  1  block can accept operands.
A  input  W  operand A.
B  input  W  operand B.
c_in  input  1  carry-in; used only when sub=0.
sub  input  1  0: S=A+B+c_in; 1: S=A-B, computed as A+~B+1.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
S  output  W  sum/difference.
c_out  output  1  carry out of bit W-1. In sub mode, 1 means no borrow.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Reset_n).
- Reset: state=IDLE; in_ready=1; out_valid=0; S=0; c_out=0; ovf=0; chunk index=0; carry reg=0. Assertion mid-operation aborts immediately and discards any partial result.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - latch A into opA.
    - latch opB = sub ? ~B : B.
    - latch carry = sub ? 1 : c_in.
    - clear idx to 0, clear S to 0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each edge:
    - S[idx*CHUNK +: CHUNK] = low CHUNK bits of opA chunk + opB chunk + carry.
    - carry = chunk carry-out; idx++.
    - On the edge processing idx==N-1: also register c_out=carry-out and ovf, then go to DONE.
  - DONE: out_valid=1, in_ready=0. S, c_out and ovf hold stable. On out_ready go to IDLE; outputs keep their values until the next accept.
- Latency: out_valid rises exactly N edges after the accepting edge (4 for the defaults; 1 when CHUNK=W).
- Throughput: one operation per N+2 cycles minimum. There is no overlap: a new operand cannot be accepted in DONE.
- ovf = (opA[W-1]==opB[W-1]) && (S[W-1]!=opA[W-1]), evaluated on the final chunk's sum bit.
- Input changes after the accept edge are ignored; operands live only in internal registers.
- in_valid while not in IDLE is ignored, not queued.
- out_ready while not in DONE has no effect.
- Arithmetic is modulo 2^W. No sign extension.

Decomposition:
- Shared package adder_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Elaboration-time check function asserting W%CHUNK==0 and CHUNK>=1.
- Sub-module chunk_adder #(CHUNK):
  - Combinational CHUNK-bit ripple of full_adder cells.
  - Ports x, y, z in; s, c out.
  - Instantiated once in the top. The top holds the FSM, index counter, carry and operand registers.

Test Plan:
1. Defaults, sub=0: A=0x00FF, B=0x0001, c_in=0 -> S=0x0100, c_out=0, ovf=0; out_valid high exactly 4 edges after accept.
2. Carry wrap: A=0xFFFF, B=0x0001, c_in=0 -> S=0x0000, c_out=1, ovf=0. Same operands with c_in=1 -> S=0x0001, c_out=1.
3. Signed overflow and subtract:
   - A=0x7FFF+B=0x0001 -> S=0x8000, ovf=1.
   - sub=1, A=0x0005, B=0x0007, c_in=1 (must be ignored) -> S=0xFFFE, c_out=0, ovf=0.
   - sub=1, A=0x8000, B=0x0001 -> S=0x7FFF, ovf=1.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle in_valid/A meanwhile -> out_valid stays 1, S stable, in_ready=0, no new accept. Raise out_ready -> IDLE next edge, in_ready=1.
5. Reset mid-operation: drop Reset_n after 2 BUSY edges -> S=0, c_out=0, out_valid=0, in_ready=1 asynchronously. A subsequent op 0x1234+0x4321 gives 0x5555 with no stale carry.
6. Parameter sweep: CHUNK=16 gives latency 1; CHUNK=1 gives latency 16. W=32/CHUNK=8 with 0xFFFFFFFF+1 -> S=0, c_out=1. 1000 random ops per config match a reference model (S, c_out, ovf).

Source files
------------

// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared FSM state type and parameter legality check for the
//               chunked sequential adder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit params_ok(input int w, input int chunk);
    return (chunk >= 1) && (chunk <= w) && ((w % chunk) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_adder.sv
// ============================================================================
// Module      : chunk_adder
// Description : Combinational CHUNK-bit ripple adder built from full_adder
//               cells; z is carry-in, c is carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             z,
  output logic [CHUNK-1:0] s,
  output logic             c
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = z;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    full_adder u_fa (
      .x (x[gi]),
      .y (y[gi]),
      .z (w_carry[gi]),
      .s (s[gi]),
      .c (w_carry[gi+1])
    );
  end

  assign c = w_carry[CHUNK];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit full adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));

endmodule

`default_nettype wire

// File: rtl/chunked_seq_adder.sv
// ============================================================================
// Module      : chunked_seq_adder
// Description : Multi-cycle W-bit adder/subtractor summing CHUNK bits per
//               cycle through a registered carry, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         c_out,
  output logic         ovf
);

  localparam int N      = W / CHUNK;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BASE_W = $clog2(W) + 1;

  if (!params_ok(W, CHUNK)) begin : g_param_check
    $error("chunked_seq_adder: W must be a multiple of CHUNK and CHUNK >= 1");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_op_a;
  logic [W-1:0]       r_op_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W-1:0]       r_s;
  logic               r_c_out;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [BASE_W-1:0]  w_base;
  logic [CHUNK-1:0]   w_sum;
  logic               w_chunk_c;

  assign w_base = BASE_W'(int'(r_idx) * CHUNK);
  assign w_last = (r_idx == IDX_W'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x (r_op_a[w_base +: CHUNK]),
    .y (r_op_b[w_base +: CHUNK]),
    .z (r_carry),
    .s (w_sum),
    .c (w_chunk_c)
  );

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is folded into addition here so BUSY never looks at sub.
      r_op_a  <= A;
      r_op_b  <= sub ? ~B : B;
      r_carry <= sub ? 1'b1 : c_in;
      r_idx   <= '0;
      r_s     <= '0;
    end else if (r_state == BUSY) begin
      r_s[w_base +: CHUNK] <= w_sum;
      r_carry              <= w_chunk_c;
      if (w_last) begin
        r_idx   <= '0;
        r_c_out <= w_chunk_c;
        r_ovf   <= (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[CHUNK-1] != r_op_a[W-1]);
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign S     = r_s;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunked_seq_adder.sv
// ============================================================================
// Module      : tb_chunked_seq_adder
// Description : Self-checking bench driving four adder configurations in
//               lockstep against a signed/unsigned arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_chunked_seq_adder;

  localparam int ND = 4;
  localparam int MAX_EDGES = 40;

  logic        Clk;
  logic        Reset_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        c_in;
  logic        sub;

  logic [ND-1:0] in_ready_all;
  logic [ND-1:0] out_valid_all;
  logic [ND-1:0] c_out_all;
  logic [ND-1:0] ovf_all;
  logic [15:0]   s0, s1, s2;
  logic [31:0]   s3;
  logic [31:0]   s_all [ND];

  int width_of [ND] = '{16, 16, 16, 32};
  int lat_exp  [ND] = '{4, 1, 16, 4};

  int          n_checks;
  int          n_pass;
  logic [ND-1:0] pre_ready;
  int          lat [ND];
  bit          timed_out;

  chunked_seq_adder #(.W(16), .CHUNK(4)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready_all[0]),
    .A(a_in[15:0]), .B(b_in[15:0]), .c_in(c_in), .sub(sub),
    .out_valid(out_valid_all[0]), .out_ready(out_ready), .S(s0),
    .c_out(c_out_all[0]), .ovf(ovf_all[0]));

  chunked_seq_adder #(.W(16), .CHUNK(16)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready_all[1]),
    .A(a_in[15:0]), .B(b_in[15:0]), .c_in(c_in), .sub(sub),
    .out_valid(out_valid_all[1]), .out_ready(out_ready), .S(s1),
    .c_out(c_out_all[1]), .ovf(ovf_all[1]));

  chunked_seq_adder #(.W(16), .CHUNK(1)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready_all[2]),
    .A(a_in[15:0]), .B(b_in[15:0]), .c_in(c_in), .sub(sub),
    .out_valid(out_valid_all[2]), .out_ready(out_ready), .S(s2),
    .c_out(c_out_all[2]), .ovf(ovf_all[2]));

  chunked_seq_adder #(.W(32), .CHUNK(8)) u_dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready_all[3]),
    .A(a_in), .B(b_in), .c_in(c_in), .sub(sub),
    .out_valid(out_valid_all[3]), .out_ready(out_ready), .S(s3),
    .c_out(c_out_all[3]), .ovf(ovf_all[3]));

  always_comb begin
    s_all[0] = {16'h0, s0};
    s_all[1] = {16'h0, s1};
    s_all[2] = {16'h0, s2};
    s_all[3] = s3;
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: plain modular arithmetic plus true signed range test.
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic sb, input logic ci,
                                output logic [31:0] s, output logic co, output logic ov);
    longint unsigned modv = 64'd1 << w;
    longint unsigned ua = a & (modv - 1);
    longint unsigned ub = b & (modv - 1);
    longint unsigned t;
    longint sa, sbv, res;
    sa  = (ua >= modv / 2) ? longint'(ua) - longint'(modv) : longint'(ua);
    sbv = (ub >= modv / 2) ? longint'(ub) - longint'(modv) : longint'(ub);
    if (sb) begin
      t   = ua + modv - ub;
      co  = (ua >= ub);
      res = sa - sbv;
    end else begin
      t   = ua + ub + longint'(ci);
      co  = (t >= modv);
      res = sa + sbv + longint'(ci);
    end
    s  = 32'(t % modv);
    ov = (res >= longint'(modv / 2)) || (res < -longint'(modv / 2));
  endfunction

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b,
                           input logic sb, input logic ci);
    @(negedge Clk);
    pre_ready = in_ready_all;
    a_in = a; b_in = b; sub = sb; c_in = ci;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    a_in = $urandom; b_in = $urandom; sub = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic wait_done();
    bit all_done;
    for (int d = 0; d < ND; d++) lat[d] = 0;
    timed_out = 1'b1;
    for (int e = 1; e <= MAX_EDGES; e++) begin
      @(negedge Clk);
      all_done = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (out_valid_all[d] && lat[d] == 0) lat[d] = e;
        if (lat[d] == 0) all_done = 1'b0;
      end
      if (all_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    #12;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (in_ready_all[d] !== 1'b1 || out_valid_all[d] !== 1'b0 || s_all[d] !== 32'h0 ||
          c_out_all[d] !== 1'b0 || ovf_all[d] !== 1'b0)
        $display("FAIL reset dut%0d: rdy=%b vld=%b S=%h co=%b ov=%b, expected 1 0 0 0 0",
                 d, in_ready_all[d], out_valid_all[d], s_all[d], c_out_all[d], ovf_all[d]);
      else n_pass++;
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'h00FF, 32'hFFFF, 32'hFFFF, 32'h7FFF, 32'h0005, 32'h8000, 32'hFFFF_FFFF};
    logic [31:0] tb [7] = '{32'h0001, 32'h0001, 32'h0001, 32'h0001, 32'h0007, 32'h0001, 32'h0000_0001};
    logic        tsb[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        tci[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] es;
    logic        eco, eov;
    for (int i = 0; i < 7; i++) begin
      accept_op(ta[i], tb[i], tsb[i], tci[i]);
      wait_done();
      n_checks++;
      if (pre_ready !== 4'hF || timed_out) $display("FAIL directed%0d handshake: in_ready=%b timeout=%0d, expected 1111 0", i, pre_ready, timed_out);
      else n_pass++;
      for (int d = 0; d < ND; d++) begin
        model(width_of[d], ta[i], tb[i], tsb[i], tci[i], es, eco, eov);
        n_checks++;
        if (s_all[d] !== es || c_out_all[d] !== eco || ovf_all[d] !== eov || lat[d] != lat_exp[d])
          $display("FAIL directed%0d dut%0d: S=%h co=%b ov=%b lat=%0d, expected S=%h co=%b ov=%b lat=%0d",
                   i, d, s_all[d], c_out_all[d], ovf_all[d], lat[d], es, eco, eov, lat_exp[d]);
        else n_pass++;
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] es [ND];
    logic        eco [ND];
    logic        eov [ND];
    for (int d = 0; d < ND; d++) model(width_of[d], 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b1, es[d], eco[d], eov[d]);
    accept_op(32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b1);
    wait_done();
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid;
      a_in = $urandom;
      @(negedge Clk);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (out_valid_all[d] !== 1'b1 || in_ready_all[d] !== 1'b0 || s_all[d] !== es[d] ||
            c_out_all[d] !== eco[d] || ovf_all[d] !== eov[d])
          $display("FAIL backpressure c%0d dut%0d: vld=%b rdy=%b S=%h, expected 1 0 %h",
                   c, d, out_valid_all[d], in_ready_all[d], s_all[d], es[d]);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    release_out();
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (out_valid_all[d] !== 1'b0 || in_ready_all[d] !== 1'b1 || s_all[d] !== es[d])
        $display("FAIL release dut%0d: vld=%b rdy=%b S=%h, expected 0 1 %h",
                 d, out_valid_all[d], in_ready_all[d], s_all[d], es[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(posedge Clk);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (in_ready_all[d] !== 1'b1 || out_valid_all[d] !== 1'b0 || s_all[d] !== 32'h0 || c_out_all[d] !== 1'b0)
        $display("FAIL reset_mid dut%0d: rdy=%b vld=%b S=%h co=%b, expected 1 0 0 0",
                 d, in_ready_all[d], out_valid_all[d], s_all[d], c_out_all[d]);
      else n_pass++;
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    accept_op(32'h1234, 32'h4321, 1'b0, 1'b0);
    wait_done();
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (timed_out || s_all[d] !== 32'h5555 || c_out_all[d] !== 1'b0 || ovf_all[d] !== 1'b0)
        $display("FAIL post_reset dut%0d: S=%h co=%b ov=%b timeout=%0d, expected 5555 0 0 0",
                 d, s_all[d], c_out_all[d], ovf_all[d], timed_out);
      else n_pass++;
    end
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] a, b, es;
    logic        sb, ci, eco, eov;
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom;
      b  = $urandom;
      sb = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      accept_op(a, b, sb, ci);
      wait_done();
      n_checks++;
      if (pre_ready !== 4'hF || timed_out) $display("FAIL random%0d handshake: in_ready=%b timeout=%0d, expected 1111 0", i, pre_ready, timed_out);
      else n_pass++;
      for (int d = 0; d < ND; d++) begin
        model(width_of[d], a, b, sb, ci, es, eco, eov);
        n_checks++;
        if (s_all[d] !== es || c_out_all[d] !== eco || ovf_all[d] !== eov || lat[d] != lat_exp[d])
          $display("FAIL random%0d dut%0d A=%h B=%h sub=%b cin=%b: S=%h co=%b ov=%b lat=%0d, expected S=%h co=%b ov=%b lat=%0d",
                   i, d, a, b, sb, ci, s_all[d], c_out_all[d], ovf_all[d], lat[d], es, eco, eov, lat_exp[d]);
        else n_pass++;
      end
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      release_out();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
